sd_blk_arbiter: RTL and testbench

//  Shares the single MiSTer SD block channel (one lba/rd/wr/ack/buffer port) among the four
//  per-drive wd1793 instances in the floppy subsystem. Round-robin grant, one block transfer at a

---
 rtl/sd_blk_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_sd_blk_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_blk_arbiter.sv
// rtl/sd_blk_arbiter.sv - round-robin sharer of the SD block channel among floppy drives
//
// Purpose:
//   Lets NDRV per-drive block requesters share one host block port (lba/rd/wr/ack/buffer).
//   One block transfer at a time. Grant rotates round-robin, starting after the drive that
//   was served last. Ack, buffer write strobe and buffer read data are routed only to and
//   from the granted drive.
//
// Ports:
//   CLK, RESET        clock, synchronous active-high reset
//   dev_lba           per-drive requested LBA (latched at grant)
//   dev_rd, dev_wr    per-drive level requests, held until acked
//   dev_ack           host_ack routed to the granted drive
//   dev_buff_wr       host_buff_wr routed to the granted drive
//   dev_buff_din      per-drive buffer read data
//   dev_err           one-cycle abort pulse on ack timeout
//   host_lba          latched LBA of the granted transfer
//   host_rd, host_wr  registered request to the host
//   host_ack          host ack, high for the whole transfer
//   host_buff_wr      host buffer write strobe
//   host_buff_din     buffer read data of the granted drive, 0 when idle
//   busy              high whenever a transfer is in progress
//
// Optional feature: define SDARB_TIMEOUT_EN to abort a request that sees no host_ack within
// TMO_CYC cycles. Without it ISSUE waits forever and dev_err is constant 0.

module sd_blk_arbiter #(
  parameter int unsigned      NDRV    = 4,
  parameter int unsigned      LBA_W   = 32,
  parameter int unsigned      TMO_W   = 24,
  parameter logic [TMO_W-1:0] TMO_CYC = 24'hFFFFFF
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [NDRV-1:0][LBA_W-1:0] dev_lba,
  input  logic [NDRV-1:0]            dev_rd,
  input  logic [NDRV-1:0]            dev_wr,
  output logic [NDRV-1:0]            dev_ack,
  output logic [NDRV-1:0]            dev_buff_wr,
  input  logic [NDRV-1:0][7:0]       dev_buff_din,
  output logic [NDRV-1:0]            dev_err,
  output logic [LBA_W-1:0]           host_lba,
  output logic                       host_rd,
  output logic                       host_wr,
  input  logic                       host_ack,
  input  logic                       host_buff_wr,
  output logic [7:0]                 host_buff_din,
  output logic                       busy
);

  localparam int unsigned     GW       = (NDRV > 1) ? $clog2(NDRV) : 1;
  localparam logic [GW-1:0]   LAST_RST = GW'(NDRV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [GW-1:0]    last_q, last_d;
  logic [LBA_W-1:0] host_lba_q, host_lba_d;
  logic             dir_q, dir_d;
  logic             host_rd_q, host_rd_d;
  logic             host_wr_q, host_wr_d;

  logic [NDRV-1:0]  req;
  logic             hit;
  logic [GW-1:0]    pick;
  logic [GW-1:0]    cand;
  int               arb_idx;
  logic             tmo_hit;

  assign req = dev_rd | dev_wr;

  // Round-robin search from last+1 upward. Walking the distance downward and overwriting
  // leaves the closest requester after 'last' as the winner.
  always_comb begin
    hit     = 1'b0;
    pick    = '0;
    cand    = '0;
    arb_idx = 0;
    for (int j = int'(NDRV); j >= 1; j--) begin
      arb_idx = int'(last_q) + j;
      if (arb_idx >= int'(NDRV)) begin
        arb_idx = arb_idx - int'(NDRV);
      end
      cand = GW'(arb_idx);
      if (req[cand]) begin
        hit  = 1'b1;
        pick = cand;
      end
    end
  end

`ifdef SDARB_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [NDRV-1:0]  dev_err_q, dev_err_d;

  // Held at zero outside ISSUE so every ISSUE entry starts from zero; saturates in ISSUE.
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == S_ISSUE) begin
      tmo_cnt_d = (&tmo_cnt_q) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
    end
  end

  // Fires on the TMO_CYC-th cycle spent in ISSUE.
  assign tmo_hit = ({1'b0, tmo_cnt_q} + 1'b1) >= {1'b0, TMO_CYC};

  // Abort pulse mirrors the FSM's timeout branch: ack and request drop take priority.
  always_comb begin
    dev_err_d = '0;
    if (state_q == S_ISSUE && !host_ack && req[grant_q] && tmo_hit) begin
      dev_err_d[grant_q] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      tmo_cnt_q <= '0;
      dev_err_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      dev_err_q <= dev_err_d;
    end
  end

  assign dev_err = dev_err_q;
`else
  assign tmo_hit = 1'b0;
  assign dev_err = '0;
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    host_lba_d = host_lba_q;
    dir_d      = dir_q;
    host_rd_d  = 1'b0;
    host_wr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hit) begin
          grant_d    = pick;
          host_lba_d = dev_lba[pick];
          dir_d      = dev_wr[pick];  // write wins when both are set
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (host_ack) begin
          state_d = S_BUSY;
        end else if (!req[grant_q]) begin
          // Drive withdrew before the host answered.
          last_d  = grant_q;
          state_d = S_IDLE;
        end else if (tmo_hit) begin
          last_d  = grant_q;
          state_d = S_IDLE;
        end else begin
          host_rd_d = ~dir_q;
          host_wr_d = dir_q;
        end
      end
      S_BUSY: begin
        if (!host_ack) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Wait for the drive to release; a fresh request is arbitrated in IDLE so the
        // other drives get their turn first.
        if (!req[grant_q]) begin
          last_d  = grant_q;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      last_q     <= LAST_RST;
      host_lba_q <= '0;
      dir_q      <= 1'b0;
      host_rd_q  <= 1'b0;
      host_wr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      host_lba_q <= host_lba_d;
      dir_q      <= dir_d;
      host_rd_q  <= host_rd_d;
      host_wr_q  <= host_wr_d;
    end
  end

  // Ack and strobe are combinational so the drive sees them in the same cycle as the host
  // drives them, including the ISSUE cycle in which ack first arrives.
  always_comb begin
    dev_ack     = '0;
    dev_buff_wr = '0;
    if (state_q == S_ISSUE || state_q == S_BUSY) begin
      dev_ack[grant_q]     = host_ack;
      dev_buff_wr[grant_q] = host_buff_wr;
    end
  end

  assign host_buff_din = (state_q != S_IDLE) ? dev_buff_din[grant_q] : 8'h00;
  assign host_lba      = host_lba_q;
  assign host_rd       = host_rd_q;
  assign host_wr       = host_wr_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_sd_blk_arbiter.sv
// tb/tb_sd_blk_arbiter.sv - self-checking bench for sd_blk_arbiter

module tb_sd_blk_arbiter;

  localparam int NDRV  = 4;
  localparam int LBA_W = 32;

  logic                       CLK = 1'b0;
  logic                       RESET;
  logic [NDRV-1:0][LBA_W-1:0] dev_lba;
  logic [NDRV-1:0]            dev_rd, dev_wr, dev_ack, dev_buff_wr, dev_err;
  logic [NDRV-1:0][7:0]       dev_buff_din;
  logic [LBA_W-1:0]           host_lba;
  logic                       host_rd, host_wr, host_ack, host_buff_wr, busy;
  logic [7:0]                 host_buff_din;

  int checks = 0;
  int errors = 0;

  sd_blk_arbiter #(
    .NDRV(NDRV), .LBA_W(LBA_W), .TMO_W(24), .TMO_CYC(24'd100)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .dev_lba(dev_lba), .dev_rd(dev_rd), .dev_wr(dev_wr),
    .dev_ack(dev_ack), .dev_buff_wr(dev_buff_wr), .dev_buff_din(dev_buff_din),
    .dev_err(dev_err),
    .host_lba(host_lba), .host_rd(host_rd), .host_wr(host_wr),
    .host_ack(host_ack), .host_buff_wr(host_buff_wr), .host_buff_din(host_buff_din),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_lba();
    for (int i = 0; i < NDRV; i++) dev_lba[i] = 32'h100 + i;
  endtask

  task automatic do_reset();
    RESET = 1'b1; dev_rd = '0; dev_wr = '0; host_ack = 1'b0; host_buff_wr = 1'b0;
    dev_buff_din = '0;
    set_lba();
    @(negedge CLK); @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!(host_rd | host_wr) && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, " request seen"}, host_rd | host_wr, 1);
  endtask

  // Serves one transfer and expects it to belong to exp_drv.
  task automatic do_xfer(input int exp_drv, input bit reraise, input string tag);
    wait_req(tag);
    chk({tag, " lba"}, host_lba, 32'h100 + exp_drv);
    host_ack = 1'b1;
    @(negedge CLK);
    chk({tag, " ack route"}, dev_ack, 4'b0001 << exp_drv);
    @(negedge CLK);
    host_ack = 1'b0;
    @(negedge CLK);
    dev_rd[exp_drv] = 1'b0; dev_wr[exp_drv] = 1'b0;
    @(negedge CLK);
    if (reraise) dev_rd[exp_drv] = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  rd;
    logic [3:0]  wr;
    logic        ack;
    logic [31:0] lba2;
    logic        e_rd;
    logic        e_wr;
    logic [3:0]  e_ack;
    logic        e_busy;
    logic [31:0] e_lba;
  } vec_t;

  function automatic vec_t mk(logic [3:0] rd, logic [3:0] wr, logic ack, logic [31:0] lba2,
                              logic e_rd, logic e_wr, logic [3:0] e_ack, logic e_busy,
                              logic [31:0] e_lba);
    vec_t v;
    v.rd = rd; v.wr = wr; v.ack = ack; v.lba2 = lba2;
    v.e_rd = e_rd; v.e_wr = e_wr; v.e_ack = e_ack; v.e_busy = e_busy; v.e_lba = e_lba;
    return v;
  endfunction

  vec_t tbl[$];

  // Random-phase state
  bit          pend[NDRV];
  bit          seen[NDRV];
  int          cool[NDRV];
  logic [31:0] rlba[NDRV];
  bit          rwr[NDRV];

  initial begin
    int cnt_bw[NDRV];
    int din_bad;
    int hstate, hcnt, mlast, mgrant, issued, served, expd, kind, n;
    logic [3:0] hist0, hist1;
    bit prev_rq, rq;

    // Drive 2 read with ack held 10 cycles, then drive 3 with rd and wr both set.
    tbl.push_back(mk(4'b0100, 4'b0000, 0, 32'h15, 0, 0, 4'b0000, 1, 32'h15));
    tbl.push_back(mk(4'b0100, 4'b0000, 0, 32'hAA, 1, 0, 4'b0000, 1, 32'h15));
    tbl.push_back(mk(4'b0100, 4'b0000, 0, 32'hAA, 1, 0, 4'b0000, 1, 32'h15));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(4'b0100, 4'b0000, 1, 32'hAA, 0, 0, 4'b0100, 1, 32'h15));
    tbl.push_back(mk(4'b0100, 4'b0000, 0, 32'hAA, 0, 0, 4'b0000, 1, 32'h15));
    tbl.push_back(mk(4'b0000, 4'b0000, 0, 32'hAA, 0, 0, 4'b0000, 0, 32'h15));
    tbl.push_back(mk(4'b1000, 4'b1000, 0, 32'hAA, 0, 0, 4'b0000, 1, 32'h103));
    tbl.push_back(mk(4'b1000, 4'b1000, 0, 32'hAA, 0, 1, 4'b0000, 1, 32'h103));
    tbl.push_back(mk(4'b1000, 4'b1000, 1, 32'hAA, 0, 0, 4'b1000, 1, 32'h103));
    tbl.push_back(mk(4'b1000, 4'b1000, 0, 32'hAA, 0, 0, 4'b0000, 1, 32'h103));
    tbl.push_back(mk(4'b0000, 4'b0000, 0, 32'hAA, 0, 0, 4'b0000, 0, 32'h103));

    // Reset state
    do_reset();
    chk("reset host_rd", host_rd, 0);
    chk("reset host_wr", host_wr, 0);
    chk("reset host_lba", host_lba, 0);
    chk("reset dev_ack", dev_ack, 0);
    chk("reset dev_err", dev_err, 0);
    chk("reset busy", busy, 0);
    chk("reset host_buff_din", host_buff_din, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      dev_rd = tbl[i].rd; dev_wr = tbl[i].wr; host_ack = tbl[i].ack; dev_lba[2] = tbl[i].lba2;
      @(negedge CLK);
      chk($sformatf("vec%0d host_rd", i), host_rd, tbl[i].e_rd);
      chk($sformatf("vec%0d host_wr", i), host_wr, tbl[i].e_wr);
      chk($sformatf("vec%0d dev_ack", i), dev_ack, tbl[i].e_ack);
      chk($sformatf("vec%0d busy", i), busy, tbl[i].e_busy);
      chk($sformatf("vec%0d host_lba", i), host_lba, tbl[i].e_lba);
    end

    // All four request at once; drive 0 re-requests right after release.
    do_reset();
    dev_rd = 4'b1111;
    do_xfer(0, 1, "rr d0");
    do_xfer(1, 0, "rr d1");
    do_xfer(2, 0, "rr d2");
    do_xfer(3, 0, "rr d3");
    do_xfer(0, 0, "rr d0 again");
    chk("rr idle busy", busy, 0);

    // 512 buffer write strobes during drive 1's transfer.
    do_reset();
    dev_rd[1] = 1'b1;
    wait_req("bw");
    host_ack = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < NDRV; i++) cnt_bw[i] = 0;
    din_bad = 0;
    for (int k = 0; k < 1024; k++) begin
      host_buff_wr = (k % 2 == 0);
      dev_buff_din = $urandom;
      @(negedge CLK);
      for (int i = 0; i < NDRV; i++) if (dev_buff_wr[i]) cnt_bw[i]++;
      if (host_buff_din !== dev_buff_din[1]) din_bad++;
    end
    host_buff_wr = 1'b0; host_ack = 1'b0;
    @(negedge CLK);
    dev_rd[1] = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < NDRV; i++)
      chk($sformatf("bw pulses drive%0d", i), cnt_bw[i], (i == 1) ? 512 : 0);
    chk("bw host_buff_din mismatches", din_bad, 0);
    chk("bw idle host_buff_din", host_buff_din, 0);

    // Reset while BUSY.
    do_reset();
    dev_rd[2] = 1'b1;
    wait_req("rst");
    host_ack = 1'b1;
    @(negedge CLK);
    chk("rst busy ack", dev_ack, 4'b0100);
    RESET = 1'b1;
    @(negedge CLK);
    chk("rst host_rd", host_rd, 0);
    chk("rst host_wr", host_wr, 0);
    chk("rst dev_ack", dev_ack, 0);
    chk("rst busy", busy, 0);
    RESET = 1'b0; host_ack = 1'b0;
    dev_rd[0] = 1'b1;
    do_xfer(0, 0, "rst next d0");
    do_xfer(2, 0, "rst then d2");

    // Request withdrawn in ISSUE; last moves to that drive.
    dev_rd[1] = 1'b1;
    wait_req("wd");
    dev_rd[1] = 1'b0;
    @(negedge CLK);
    chk("wd host_rd dropped", host_rd, 0);
    chk("wd busy", busy, 0);
    dev_rd[1] = 1'b1; dev_rd[2] = 1'b1;
    do_xfer(2, 0, "wd d2 first");
    do_xfer(1, 0, "wd d1 second");

`ifdef SDARB_TIMEOUT_EN
    do_reset();
    dev_rd[1] = 1'b1; dev_rd[2] = 1'b1;
    wait_req("tmo");
    n = 0;
    while (host_rd && n < 200) begin
      n++;
      @(negedge CLK);
    end
    chk("tmo host_rd cycles", n, 99);
    chk("tmo host_rd dropped", host_rd, 0);
    chk("tmo dev_err pulse", dev_err, 4'b0010);
    @(negedge CLK);
    chk("tmo dev_err cleared", dev_err, 0);
    dev_rd[1] = 1'b0;
    do_xfer(2, 0, "tmo next d2");
`endif

    // Randomized traffic against a round-robin reference model.
    do_reset();
    for (int i = 0; i < NDRV; i++) begin
      pend[i] = 0; seen[i] = 0; cool[i] = 0; rlba[i] = 0; rwr[i] = 0;
    end
    hstate = 0; hcnt = 0; mlast = NDRV - 1; mgrant = 0; issued = 0; served = 0;
    hist0 = '0; hist1 = '0; prev_rq = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rq = host_rd | host_wr;
      chk("rnd dev_err", dev_err, 0);
      chk("rnd rd wr exclusive", host_rd & host_wr, 0);
      if (rq && !prev_rq) begin
        expd = -1;
        for (int j = 1; j <= NDRV; j++)
          if (expd < 0 && hist1[(mlast + j) % NDRV]) expd = (mlast + j) % NDRV;
        chk("rnd grant exists", expd >= 0, 1);
        if (expd >= 0) begin
          mgrant = expd; mlast = expd;
          chk("rnd host_lba", host_lba, rlba[expd]);
          chk("rnd host_wr dir", host_wr, rwr[expd]);
        end
      end
      chk("rnd dev_ack", dev_ack, host_ack ? (4'b0001 << mgrant) : 4'b0000);
      chk("rnd dev_buff_wr", dev_buff_wr, host_buff_wr ? (4'b0001 << mgrant) : 4'b0000);
      if (host_ack) chk("rnd host_buff_din", host_buff_din, dev_buff_din[mgrant]);
      prev_rq = rq;

      for (int i = 0; i < NDRV; i++) begin
        if (pend[i]) begin
          if (dev_ack[i]) seen[i] = 1;
          else if (seen[i]) begin
            pend[i] = 0; seen[i] = 0; dev_rd[i] = 0; dev_wr[i] = 0;
            served++;
            cool[i] = $urandom_range(0, 4);
          end
        end else if (cool[i] > 0) begin
          cool[i]--;
        end else if (cyc < 3500 && $urandom_range(0, 3) == 0) begin
          pend[i] = 1;
          rlba[i] = $urandom;
          dev_lba[i] = rlba[i];
          kind = $urandom_range(0, 2);
          dev_rd[i] = (kind != 1);
          dev_wr[i] = (kind != 0);
          rwr[i] = (kind != 0);
          issued++;
        end
      end
      dev_buff_din = $urandom;

      if (hstate == 0 && rq) begin
        hcnt = $urandom_range(0, 3);
        hstate = 1;
      end
      if (hstate == 1) begin
        if (hcnt == 0) begin
          host_ack = 1'b1;
          hcnt = $urandom_range(1, 8);
          hstate = 2;
        end else hcnt--;
      end else if (hstate == 2) begin
        if (hcnt == 0) begin
          host_ack = 1'b0; host_buff_wr = 1'b0; hstate = 0;
        end else begin
          hcnt--;
          host_buff_wr = 1'($urandom_range(0, 1));
        end
      end

      hist1 = hist0;
      hist0 = dev_rd | dev_wr;
      @(negedge CLK);
    end
    chk("rnd drained busy", busy, 0);
    chk("rnd served all", served, issued);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
